// File: rtl/switch_debouncer.sv
// Switch debouncer: two-flop synchronizer followed by a four-state qualifier.
// Clean changes only after the synchronized input has held a new level for
// STABLE_CYCLES consecutive qualifier cycles. Rise and Fall are one-cycle
// strobes that accompany each accepted change of Clean.
//
// Handshake: this block has no valid/ready interface. Raw is sampled on every
// clock edge. Rise and Fall are single-cycle strobes that the consumer must
// accept in the cycle they are high. They are never held waiting for an
// acknowledge.
module switch_debouncer #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       Raw,
  output logic       Clean,
  output logic       Rise,
  output logic       Fall,
  output logic       Busy,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // Terminal count: the qualifying sample is the one seen while cnt holds this value.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_s1;
  logic             r_s2;
  logic             r_clean;
  logic             r_rise;
  logic             r_fall;
  logic             r_busy;

  // Synchronizer, qualification FSM and registered outputs in one clocked process.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_s1   <= Raw;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        IDLE_LOW: begin
          if (r_s2) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (!r_s2) begin
            // Bounce: drop the candidate, qualification restarts from zero.
            r_state <= IDLE_LOW;
            r_busy  <= 1'b0;
          end else if (r_cnt == LAST) begin
            r_state <= IDLE_HIGH;
            r_clean <= 1'b1;
            r_rise  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            // Never reaches past LAST, so the counter cannot wrap.
            r_cnt <= r_cnt + ONE;
          end
        end
        IDLE_HIGH: begin
          if (!r_s2) begin
            r_state <= WAIT_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (r_s2) begin
            r_state <= IDLE_HIGH;
            r_busy  <= 1'b0;
          end else if (r_cnt == LAST) begin
            r_state <= IDLE_LOW;
            r_clean <= 1'b0;
            r_fall  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        default: begin
          r_state <= IDLE_LOW;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Clean       = r_clean;
  assign Rise        = r_rise;
  assign Fall        = r_fall;
  assign Busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_switch_debouncer.sv
// Testbench for switch_debouncer with STABLE_CYCLES=4, CNT_W=3.
// Reference model: a debounced level changes once the synchronized input has
// disagreed with it on STABLE_CYCLES+1 consecutive cycles. The FSM needs one
// cycle to leave idle and then counts STABLE_CYCLES samples.
module tb_switch_debouncer;

  localparam int STABLE = 4;

  logic       clk;
  logic       rst;
  logic       raw;
  logic       clean;
  logic       rise;
  logic       fall;
  logic       busy;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic m_d1, m_d2;          // raw value delayed by one and two edges
  logic m_clean, m_rise, m_fall;
  int   m_run;               // consecutive synchronized samples differing from m_clean

  int rise_cnt, fall_cnt;    // strobes observed from the DUT

  switch_debouncer #(.STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
    .CLOCK_50    (clk),
    .Reset       (rst),
    .Raw         (raw),
    .Clean       (clean),
    .Rise        (rise),
    .Fall        (fall),
    .Busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_d1 = 1'b0; m_d2 = 1'b0; m_clean = 1'b0;
    m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
  endtask

  task automatic model_step(input logic r, input logic rs);
    logic seen;
    if (rs) begin
      model_reset();
    end else begin
      seen = m_d2;
      m_d2 = m_d1;
      m_d1 = r;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (seen != m_clean) begin
        m_run++;
        if (m_run == STABLE + 1) begin
          m_clean = seen;
          m_rise  = seen;
          m_fall  = !seen;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  // driver: one clock cycle with given inputs, then compare at the falling edge
  task automatic cycle(input logic r, input logic rs);
    raw = r;
    rst = rs;
    @(posedge clk);
    model_step(r, rs);
    @(negedge clk);
    check_eq("clean", clean, m_clean);
    check_eq("rise",  rise,  m_rise);
    check_eq("fall",  fall,  m_fall);
    check_eq("busy",  busy,  (m_run > 0));
    check_eq("rise_fall_excl", rise & fall, 0);
    if (rise) rise_cnt++;
    if (fall) fall_cnt++;
  endtask

  task automatic hold(input logic r, input int n);
    for (int i = 0; i < n; i++) cycle(r, 1'b0);
  endtask

  initial begin
    raw = 1'b0;
    rst = 1'b1;
    model_reset();
    rise_cnt = 0;
    fall_cnt = 0;
    @(negedge clk);

    // 1: reset held, then quiet input
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
    check_eq("reset_clean", clean, 0);
    check_eq("reset_busy", busy, 0);
    hold(1'b0, 20);
    check_eq("s1_no_strobes", rise_cnt + fall_cnt, 0);

    // 2: clean rising edge
    rise_cnt = 0;
    cycle(1'b1, 1'b0);          // edge k
    cycle(1'b1, 1'b0);          // k+1
    check_eq("s2_busy_k1", busy, 0);
    cycle(1'b1, 1'b0);          // k+2
    check_eq("s2_busy_k2", busy, 1);
    hold(1'b1, 3);              // k+3..k+5
    check_eq("s2_clean_k5", clean, 0);
    cycle(1'b1, 1'b0);          // k+6
    check_eq("s2_clean_k6", clean, 1);
    check_eq("s2_rise_k6", rise, 1);
    cycle(1'b1, 1'b0);          // k+7
    check_eq("s2_rise_k7", rise, 0);
    check_eq("s2_busy_k7", busy, 0);
    hold(1'b1, 5);
    check_eq("s2_one_rise", rise_cnt, 1);

    // 4: falling edge from Clean=1
    rise_cnt = 0; fall_cnt = 0;
    hold(1'b0, 6);              // k..k+5
    check_eq("s4_clean_k5", clean, 1);
    cycle(1'b0, 1'b0);          // k+6
    check_eq("s4_fall_k6", fall, 1);
    check_eq("s4_clean_k6", clean, 0);
    hold(1'b0, 5);
    check_eq("s4_one_fall", fall_cnt, 1);
    check_eq("s4_no_rise", rise_cnt, 0);

    // 3: bounce 1,1,0 five times, then settle high
    rise_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
    end
    hold(1'b0, 2);
    check_eq("s3_no_rise_bounce", rise_cnt, 0);
    hold(1'b1, 6);
    check_eq("s3_clean_k5", clean, 0);
    cycle(1'b1, 1'b0);
    check_eq("s3_rise_k6", rise, 1);
    hold(1'b1, 4);
    check_eq("s3_one_rise", rise_cnt, 1);

    // 5: reset during WAIT_HIGH
    hold(1'b0, 10);
    rise_cnt = 0;
    hold(1'b1, 4);
    check_eq("s5_busy_before", busy, 1);
    cycle(1'b1, 1'b1);
    check_eq("s5_busy_reset", busy, 0);
    check_eq("s5_clean_reset", clean, 0);
    hold(1'b1, 6);              // first non-reset edge plus k+1..k+5
    check_eq("s5_no_early_rise", rise_cnt, 0);
    cycle(1'b1, 1'b0);          // k+6
    check_eq("s5_rise_k6", rise, 1);
    hold(1'b1, 5);
    check_eq("s5_one_rise", rise_cnt, 1);

    // 6: short high pulse
    hold(1'b0, 10);
    rise_cnt = 0; fall_cnt = 0;
    hold(1'b1, 3);
    hold(1'b0, 1);
    check_eq("s6_busy_pulse", busy, 1);
    hold(1'b0, 10);
    check_eq("s6_clean", clean, 0);
    check_eq("s6_no_strobes", rise_cnt + fall_cnt, 0);

    // randomized bouncing input with occasional resets
    for (int seg = 0; seg < 300; seg++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 40) == 0) cycle(lvl, 1'b1);
      hold(lvl, len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
